io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_resp_pkg.sv | 25 ++
 rtl/io_fifo.sv | 71 +++++++
 rtl/io_responder.sv | 140 ++++++++++++++
 tb/tb_io_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_resp_pkg.sv
// Shared definitions for io_responder: data width, handshake FSM states and
// the saturating statistics increment.
package io_resp_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    I_IDLE     = 2'd0,
    I_ACK      = 2'd1,
    I_WAIT_LOW = 2'd2
  } inp_state_e;

  typedef enum logic [1:0] {
    O_IDLE     = 2'd0,
    O_ACK      = 2'd1,
    O_WAIT_LOW = 2'd2
  } out_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with wrapping pointers and a separate occupancy count.
// The head word is presented combinationally so a consumer can take it on the pop edge.
module io_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FULL_CNT);
  assign head_data_o = mem_q[rd_ptr_q];

  // Guard against misuse: never overwrite a full FIFO or pop an empty one.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/io_responder.sv
// CPU-side request/ack responder bridging an input FIFO (src -> CPU) and an
// output FIFO (CPU -> snk). Optional counters enabled by IO_RESPONDER_STATS_EN.
module io_responder
  import io_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              inp_req,
  output logic              inp_ack,
  output logic [DATA_W-1:0] inp_data,
  input  logic              out_req,
  input  logic [DATA_W-1:0] out_data,
  output logic              out_ack,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              snk_valid,
  output logic [DATA_W-1:0] snk_data,
  input  logic              snk_ready
`ifdef IO_RESPONDER_STATS_EN
  ,
  output logic [CNT_W-1:0]  inp_count,
  output logic [CNT_W-1:0]  out_count
`endif
);

  logic              in_empty, in_full, in_pop;
  logic [DATA_W-1:0] in_head;
  logic              out_empty, out_full, out_push;

  inp_state_e        inp_state_q, inp_state_d;
  out_state_e        out_state_q, out_state_d;
  logic [DATA_W-1:0] inp_data_q, inp_data_d;

  io_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_in_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .push_i     (src_valid & ~in_full),
    .push_data_i(src_data),
    .pop_i      (in_pop),
    .head_data_o(in_head),
    .empty_o    (in_empty),
    .full_o     (in_full)
  );

  io_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_out_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .push_i     (out_push),
    .push_data_i(out_data),
    .pop_i      (snk_ready & ~out_empty),
    .head_data_o(snk_data),
    .empty_o    (out_empty),
    .full_o     (out_full)
  );

  assign src_ready = ~in_full;
  assign snk_valid = ~out_empty;
  assign inp_data  = inp_data_q;
  assign inp_ack   = (inp_state_q == I_ACK);
  assign out_ack   = (out_state_q == O_ACK);

  // Input channel: the head word is captured and popped on the accepting edge.
  always_comb begin
    inp_state_d = inp_state_q;
    inp_data_d  = inp_data_q;
    in_pop      = 1'b0;
    case (inp_state_q)
      I_IDLE: begin
        if (inp_req && !in_empty) begin
          in_pop      = 1'b1;
          inp_data_d  = in_head;
          inp_state_d = I_ACK;
        end
      end
      I_ACK:      inp_state_d = I_WAIT_LOW;
      I_WAIT_LOW: if (!inp_req) inp_state_d = I_IDLE;
      default:    inp_state_d = I_IDLE;
    endcase
  end

  // Output channel: fullness is judged on the current occupancy, so a pop on
  // the same edge only makes room for the following edge.
  always_comb begin
    out_state_d = out_state_q;
    out_push    = 1'b0;
    case (out_state_q)
      O_IDLE: begin
        if (out_req && !out_full) begin
          out_push    = 1'b1;
          out_state_d = O_ACK;
        end
      end
      O_ACK:      out_state_d = O_WAIT_LOW;
      O_WAIT_LOW: if (!out_req) out_state_d = O_IDLE;
      default:    out_state_d = O_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      inp_state_q <= I_IDLE;
      out_state_q <= O_IDLE;
      inp_data_q  <= '0;
    end else begin
      inp_state_q <= inp_state_d;
      out_state_q <= out_state_d;
      inp_data_q  <= inp_data_d;
    end
  end

`ifdef IO_RESPONDER_STATS_EN
  logic [CNT_W-1:0] inp_count_q, inp_count_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  assign inp_count_d = inp_ack ? sat_inc(inp_count_q) : inp_count_q;
  assign out_count_d = out_ack ? sat_inc(out_count_q) : out_count_q;
  assign inp_count   = inp_count_q;
  assign out_count   = out_count_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      inp_count_q <= '0;
      out_count_q <= '0;
    end else begin
      inp_count_q <= inp_count_d;
      out_count_q <= out_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed scenarios plus randomized
// traffic, all compared against a queue-based transaction model.
module tb_io_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        inp_req, inp_ack;
  logic [15:0] inp_data;
  logic        out_req, out_ack;
  logic [15:0] out_data;
  logic        src_valid, src_ready;
  logic [15:0] src_data;
  logic        snk_valid, snk_ready;
  logic [15:0] snk_data;
`ifdef IO_RESPONDER_STATS_EN
  logic [15:0] inp_count, out_count;
`endif

  always #5 clk = ~clk;

  io_responder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .inp_req  (inp_req),
    .inp_ack  (inp_ack),
    .inp_data (inp_data),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .snk_valid(snk_valid),
    .snk_data (snk_data),
    .snk_ready(snk_ready)
`ifdef IO_RESPONDER_STATS_EN
    ,
    .inp_count(inp_count),
    .out_count(out_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: FIFO contents as queues, one "served" flag per
  // CPU request (a held request is answered at most once).
  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  logic [15:0] dut_sink[$];
  logic        inp_served, out_served;
  logic        exp_inp_ack, exp_out_ack;
  logic [15:0] exp_inp_data;
  int          inp_cnt_m, out_cnt_m;
  int          inp_low, out_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_q.delete();
    out_q.delete();
    inp_served   = 1'b0;
    out_served   = 1'b0;
    exp_inp_ack  = 1'b0;
    exp_out_ack  = 1'b0;
    exp_inp_data = 16'h0;
    inp_cnt_m    = 0;
    out_cnt_m    = 0;
  endtask

  task automatic check_outputs();
    chk("inp_ack", 32'(inp_ack), 32'(exp_inp_ack));
    chk("inp_data", 32'(inp_data), 32'(exp_inp_data));
    chk("out_ack", 32'(out_ack), 32'(exp_out_ack));
    chk("src_ready", 32'(src_ready), 32'(in_q.size() < DEPTH));
    chk("snk_valid", 32'(snk_valid), 32'(out_q.size() > 0));
    if (out_q.size() > 0) chk("snk_data", 32'(snk_data), 32'(out_q[0]));
`ifdef IO_RESPONDER_STATS_EN
    chk("inp_count", 32'(inp_count), 32'(inp_cnt_m));
    chk("out_count", 32'(out_count), 32'(out_cnt_m));
`endif
  endtask

  // One clock: predict the edge from current inputs, then compare at the next negedge.
  task automatic step();
    int   in_sz, out_sz;
    logic pop_i, push_o;
    in_sz  = in_q.size();
    out_sz = out_q.size();
    pop_i  = inp_req && !inp_served && (in_sz > 0);
    push_o = out_req && !out_served && (out_sz < DEPTH);
    exp_inp_ack = pop_i;
    exp_out_ack = push_o;
    if (snk_valid && snk_ready) dut_sink.push_back(snk_data);
    if (pop_i) begin
      exp_inp_data = in_q.pop_front();
      inp_served   = 1'b1;
      if (inp_cnt_m < 65535) inp_cnt_m++;
    end
    if (src_valid && in_sz < DEPTH) in_q.push_back(src_data);
    if (snk_ready && out_sz > 0) void'(out_q.pop_front());
    if (push_o) begin
      out_q.push_back(out_data);
      out_served = 1'b1;
      if (out_cnt_m < 65535) out_cnt_m++;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic src_push(input logic [15:0] d);
    src_valid = 1'b1;
    src_data  = d;
    step();
    src_valid = 1'b0;
  endtask

  task automatic cpu_read();
    int n = 0;
    inp_req = 1'b1;
    step();
    while (!inp_ack && n < 20) begin
      step();
      n++;
    end
    chk("cpu_read_ack", 32'(inp_ack), 32'(1));
    inp_req    = 1'b0;
    inp_served = 1'b0;
    step();
    step();
  endtask

  task automatic cpu_write(input logic [15:0] d);
    int n = 0;
    out_req  = 1'b1;
    out_data = d;
    step();
    while (!out_ack && n < 20) begin
      step();
      n++;
    end
    chk("cpu_write_ack", 32'(out_ack), 32'(1));
    out_req    = 1'b0;
    out_served = 1'b0;
    step();
    step();
  endtask

  // Protocol-respecting random CPU: drop a request once served, keep it low
  // for at least two edges before raising it again.
  task automatic drive_rand(input bit full_rate);
    src_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
    src_data  = 16'($urandom);
    snk_ready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (inp_req) begin
      if (inp_served) begin
        inp_req    = 1'b0;
        inp_served = 1'b0;
        inp_low    = $urandom_range(1, 3);
      end
    end else if (inp_low > 0) begin
      inp_low--;
    end else begin
      inp_req = 1'($urandom_range(0, 1));
    end
    if (out_req) begin
      if (out_served) begin
        out_req    = 1'b0;
        out_served = 1'b0;
        out_low    = $urandom_range(1, 3);
      end
    end else if (out_low > 0) begin
      out_low--;
    end else begin
      out_req = 1'($urandom_range(0, 1));
      if (out_req) out_data = 16'($urandom);
    end
  endtask

  initial begin
    int n;
    int acks;
    rst_b     = 1'b0;
    inp_req   = 1'b0;
    out_req   = 1'b0;
    out_data  = 16'h0;
    src_valid = 1'b0;
    src_data  = 16'h0;
    snk_ready = 1'b0;
    inp_low   = 1;
    out_low   = 1;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst_b = 1'b1;
    step();
    $display("reset released, idle outputs checked");

    // Single read with the request held across its own ack.
    src_push(16'h1234);
    inp_req = 1'b1;
    step();
    chk("r031_ack", 32'(inp_ack), 32'(1));
    chk("r031_data", 32'(inp_data), 32'h1234);
    acks = 0;
    repeat (5) begin
      step();
      if (inp_ack) acks++;
    end
    chk("r031_no_second_ack", 32'(acks), 32'(0));
    inp_req    = 1'b0;
    inp_served = 1'b0;
    step();
    step();
    $display("held read: data %h, extra acks %0d", inp_data, acks);

    // Request against an empty FIFO, word arrives later.
    inp_req = 1'b1;
    repeat (5) step();
    src_push(16'hBEEF);
    n = 0;
    while (!inp_ack && n < 10) begin
      step();
      n++;
    end
    chk("r032_latency", 32'(n + 1), 32'(2));
    chk("r032_data", 32'(inp_data), 32'hBEEF);
    inp_req    = 1'b0;
    inp_served = 1'b0;
    step();
    step();
    $display("late word read: %0d cycles after push, data %h", n + 1, inp_data);

    // Fill the output FIFO, stall the fifth write, then drain.
    snk_ready = 1'b0;
    for (int d = 1; d <= 4; d++) cpu_write(16'(d));
    out_req  = 1'b1;
    out_data = 16'h0005;
    acks = 0;
    repeat (6) begin
      step();
      if (out_ack) acks++;
    end
    chk("r033_stall", 32'(acks), 32'(0));
    dut_sink.delete();
    snk_ready = 1'b1;
    n = 0;
    while (!out_ack && n < 10) begin
      step();
      n++;
    end
    chk("r033_fifth_ack", 32'(out_ack), 32'(1));
    out_req    = 1'b0;
    out_served = 1'b0;
    n = 0;
    while (snk_valid && n < 20) begin
      step();
      n++;
    end
    step();
    chk("r033_sink_count", 32'(dut_sink.size()), 32'(5));
    for (int i = 0; i < dut_sink.size() && i < 5; i++) begin
      chk("r033_sink_order", 32'(dut_sink[i]), 32'(i + 1));
    end
    $display("full-FIFO write: stalled acks %0d, sink words %0d", acks, dut_sink.size());

    // Full-rate streaming on both external ports.
    inp_low = 1;
    out_low = 1;
    for (int i = 0; i < 20; i++) begin
      drive_rand(1'b1);
      step();
    end
    $display("full-rate stream: 20 cycles, input occupancy %0d", in_q.size());

    // Reset while an output ack is showing and two words are buffered.
    inp_req    = 1'b0;
    out_req    = 1'b0;
    inp_served = 1'b0;
    out_served = 1'b0;
    src_valid  = 1'b0;
    snk_ready  = 1'b1;
    n = 0;
    while ((out_q.size() > 0 || inp_ack || out_ack) && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    snk_ready = 1'b0;
    src_push(16'hAAAA);
    cpu_write(16'h0A0A);
    out_req  = 1'b1;
    out_data = 16'h0B0B;
    n = 0;
    step();
    while (!out_ack && n < 10) begin
      step();
      n++;
    end
    chk("r035_pre_ack", 32'(out_ack), 32'(1));
    chk("r035_pre_words", 32'(out_q.size()), 32'(2));
    rst_b = 1'b0;
    #1;
    chk("r035_out_ack", 32'(out_ack), 32'(0));
    chk("r035_snk_valid", 32'(snk_valid), 32'(0));
    chk("r035_src_ready", 32'(src_ready), 32'(1));
    chk("r035_inp_data", 32'(inp_data), 32'(0));
    out_req = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_b     = 1'b1;
    snk_ready = 1'b1;
    inp_req   = 1'b1;
    repeat (4) step();
    inp_req = 1'b0;
    step();
    step();
    $display("mid-handshake reset: snk_valid %0b after release", snk_valid);

    // Three reads and two writes from a clean reset state.
    for (int i = 0; i < 3; i++) src_push(16'(16'h0100 + i));
    for (int i = 0; i < 3; i++) cpu_read();
    cpu_write(16'h0C01);
    cpu_write(16'h0C02);
    chk("r036_inp_transfers", 32'(inp_cnt_m), 32'(3));
`ifdef IO_RESPONDER_STATS_EN
    chk("r036_inp_count", 32'(inp_count), 32'(3));
    chk("r036_out_count", 32'(out_count), 32'(2));
`endif
    $display("stats scenario: %0d reads, %0d writes", inp_cnt_m, out_cnt_m);

    // Randomized traffic on all four interfaces.
    inp_low = 1;
    out_low = 1;
    for (int i = 0; i < 400; i++) begin
      drive_rand(1'b0);
      step();
    end
    $display("random traffic: 400 cycles, sink words %0d", dut_sink.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
